sa_oport: RTL
=============

Name: sa_oport

Overview:
- Output-port stage of the separable switch allocator; one instance per router output port.
- Receives per-input-port requests already filtered by each input port's local VC arbitration. Selects one input per cycle using a rotating round-robin priority.
- Gates grants on downstream credit availability and, optionally, holds the grant for the whole packet (wormhole lock).
- Returns a same-cycle grant to the input stages and drives a registered one-hot select for the crossbar traversal stage.

Parameters:
- N, 5, number of router input ports (requesters).
- DEPTH, 4, downstream input buffer depth in flits; initial and maximum credit count.
- CW, 3, credit counter width; must satisfy 2^CW > DEPTH.

Ports:
- clk  input  1  system clock.
- rstn  input  1  asynchronous active-low reset.
- reqIn  input  N  bit i set: input port i requests this output this cycle.
- tailIn  input  N  bit i set: the flit offered by input i is a tail (or single-flit) flit; qualified by reqIn[i].
- creditIn  input  1  one-cycle pulse; downstream freed one buffer slot.
- grantOut  output  N  one-hot or zero, combinational; winner for this cycle.
- xbarSelOut  output  N  registered copy of grantOut; crossbar column select for the next cycle.
- flitValidOut  output  1  registered; high when xbarSelOut is non-zero.
- creditCntOut  output  CW  current credit count.
- lockedOut  output  1  high while the port is locked to an input mid-packet.
- errOvfOut  output  1  sticky; a credit was returned while the count was already DEPTH.

Behaviour:
Reset (async, rstn low):
- prio pointer = 0; credit = DEPTH; state = IDLE; lockOwner = 0.
- xbarSelOut = 0; flitValidOut = 0; errOvfOut = 0.
- grantOut is 0 while rstn is low.

Eligibility:
- A grant can only occur when credit != 0. With credit == 0, grantOut = 0 regardless of reqIn.

IDLE arbitration:
- Winner is the first set bit of reqIn, searching upward from index prio with wrap from N-1 to 0.
- grantOut is the one-hot winner; computed combinationally in the same cycle.

Pointer update:
- On a grant with tailIn[w] = 1, prio <= (w+1) mod N.
- On a non-tail grant, prio is unchanged.
- With no grant, prio holds.

State machine:
- IDLE -> LOCKED: grant of a non-tail flit from input w. Set lockOwner <= w.
- LOCKED: grantOut[lockOwner] = reqIn[lockOwner] AND credit != 0. All other inputs are masked.
- LOCKED -> IDLE: a granted flit from lockOwner has tailIn set.
- A single-flit packet (tail on the first grant) stays in IDLE.

Locked stalls:
- If lockOwner drops its request, no grant is issued that cycle and the state stays LOCKED. There is no timeout.

Credit counter:
- Decrements by 1 on a grant; increments by 1 on creditIn.
- Grant and creditIn in the same cycle: count unchanged.
- creditIn at count == DEPTH with no grant: count stays DEPTH (saturates) and errOvfOut sets. errOvfOut clears only on reset.

Registered outputs:
- xbarSelOut <= grantOut and flitValidOut <= |grantOut, every cycle.
- Latency from request to crossbar select is 1 cycle.

Status outputs:
- lockedOut = (state == LOCKED).
- creditCntOut shows the registered count, i.e. the value before the current cycle's update.

Reset mid-packet:
- State returns to IDLE and the lock is dropped. Credit returns to DEPTH; the upstream flow-control reset is responsible for consistency.

Optional Feature:
- Macro SA_OPORT_LOCK_EN.
- Defined: wormhole lock as described above; LOCKED state present; lockedOut functional.
- Undefined: no LOCKED state and lockedOut is tied to 0. Every cycle is an IDLE arbitration, so flits from different inputs may interleave. prio still advances only on tail grants, and credit gating is unchanged.
- Use the undefined configuration for VC routers with per-VC downstream buffers.

Test Plan:
- Reset then reqIn=5'b00110, tailIn=5'b00110, credit 4 -> grantOut=00010; next cycle xbarSelOut=00010, flitValidOut=1, creditCntOut=3, prio=2.
- Round-robin fairness: reqIn=11111 held with all tail flits and credit replenished each cycle -> grant sequence 00001, 00010, 00100, 01000, 10000, 00001.
- Lock (SA_OPORT_LOCK_EN): input 3 sends head (tail=0) with reqIn=11111 -> grants 01000 for three cycles while others are masked and lockedOut=1. The tail on the third grant -> lockedOut=0 and prio=4.
- Credit exhaustion: DEPTH=4, reqIn=00001 tail each cycle, no creditIn -> four grants, then grantOut=0 while creditCntOut=0. One creditIn pulse -> exactly one further grant.
- Simultaneous grant and creditIn at count 2 -> count stays 2. creditIn at count 4 with no request -> count 4, errOvfOut=1 and it stays 1 afterwards.
- Assert rstn low while LOCKED with credit 1 -> immediately lockedOut=0, grantOut=0, xbarSelOut=0. After release, creditCntOut=4 and the next request arbitrates from prio 0.

Source files
------------

// File: rtl/sa_oport.sv
// -----------------------------------------------------------------------------
// sa_oport : output-port stage of the separable switch allocator.
//
// One instance sits on each router output port. It picks one of N input ports
// per cycle with a rotating round-robin priority. Grants are gated on downstream
// credit. Optionally, the port can stay locked to one input for a whole packet
// (wormhole lock).
//
// Optional feature macro: SA_OPORT_LOCK_EN
//   defined   : wormhole lock. A non-tail grant locks the port to its input
//               until that input's tail flit is granted.
//   undefined : every cycle is a free arbitration and lockedOut is tied to 0.
//
// Ports
//   clk          system clock
//   rstn         asynchronous active-low reset
//   reqIn[N]     per-input request (already VC-arbitrated upstream)
//   tailIn[N]    per-input tail/single-flit marker, qualified by reqIn
//   creditIn     one-cycle pulse: downstream freed one buffer slot
//   grantOut[N]  combinational one-hot (or zero) winner for this cycle
//   xbarSelOut   registered grantOut; crossbar column select
//   flitValidOut registered; high when xbarSelOut is non-zero
//   creditCntOut registered credit count (value before this cycle's update)
//   lockedOut    high while locked to an input mid-packet
//   errOvfOut    sticky credit-overflow flag (credit returned at DEPTH)
// -----------------------------------------------------------------------------
module sa_oport #(
   parameter int N     = 5,
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [N-1:0]  reqIn,
   input  logic [N-1:0]  tailIn,
   input  logic          creditIn,
   output logic [N-1:0]  grantOut,
   output logic [N-1:0]  xbarSelOut,
   output logic          flitValidOut,
   output logic [CW-1:0] creditCntOut,
   output logic          lockedOut,
   output logic          errOvfOut
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] prio_q, prio_d;
   logic [CW-1:0] credit_q, credit_d;
   logic [N-1:0]  xbar_sel_q, xbar_sel_d;
   logic          flit_valid_q, flit_valid_d;
   logic          err_ovf_q, err_ovf_d;

`ifdef SA_OPORT_LOCK_EN
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t        state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
`endif

   // Round-robin search: the first requester found when scanning upward from
   // prio_q and wrapping from N-1 back to 0.
   logic          win_found;
   logic [PW-1:0] win_idx;

   always_comb begin
      int idx;
      win_found = 1'b0;
      win_idx   = '0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(prio_q) + k) % N;
         if (!win_found && reqIn[idx]) begin
            win_found = 1'b1;
            win_idx   = PW'(idx);
         end
      end
   end

   // Grant generation plus all next-state logic.
   logic [N-1:0]  grant;
   logic [PW-1:0] gnt_idx;
   logic          grant_any;
   logic          gnt_tail;

   always_comb begin
      grant   = '0;
      gnt_idx = win_idx;
`ifdef SA_OPORT_LOCK_EN
      // While locked, only the owner may be granted; others are masked.
      if (state_q == LOCKED) begin
         gnt_idx = owner_q;
      end
      if (rstn && (credit_q != '0)) begin
         if (state_q == LOCKED) begin
            grant[owner_q] = reqIn[owner_q];
         end else if (win_found) begin
            grant[win_idx] = 1'b1;
         end
      end
`else
      if (rstn && (credit_q != '0) && win_found) begin
         grant[win_idx] = 1'b1;
      end
`endif
      grant_any = |grant;
      gnt_tail  = tailIn[gnt_idx];

      // The priority pointer moves only when a packet completes.
      prio_d = prio_q;
      if (grant_any && gnt_tail) begin
         prio_d = PW'((int'(gnt_idx) + 1) % N);
      end

`ifdef SA_OPORT_LOCK_EN
      state_d = state_q;
      owner_d = owner_q;
      if (grant_any) begin
         if (gnt_tail) begin
            state_d = IDLE;
         end else if (state_q == IDLE) begin
            state_d = LOCKED;
            owner_d = gnt_idx;
         end
      end
`endif

      // A grant and a returned credit in the same cycle cancel. A credit
      // returned at DEPTH with no grant is a protocol error; saturate and flag.
      credit_d  = credit_q;
      err_ovf_d = err_ovf_q;
      if (grant_any && !creditIn) begin
         credit_d = credit_q - CW'(1);
      end else if (!grant_any && creditIn) begin
         if (credit_q == CW'(DEPTH)) begin
            err_ovf_d = 1'b1;
         end else begin
            credit_d = credit_q + CW'(1);
         end
      end

      xbar_sel_d   = grant;
      flit_valid_d = grant_any;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         prio_q       <= '0;
         credit_q     <= CW'(DEPTH);
         xbar_sel_q   <= '0;
         flit_valid_q <= 1'b0;
         err_ovf_q    <= 1'b0;
`ifdef SA_OPORT_LOCK_EN
         state_q      <= IDLE;
         owner_q      <= '0;
`endif
      end else begin
         prio_q       <= prio_d;
         credit_q     <= credit_d;
         xbar_sel_q   <= xbar_sel_d;
         flit_valid_q <= flit_valid_d;
         err_ovf_q    <= err_ovf_d;
`ifdef SA_OPORT_LOCK_EN
         state_q      <= state_d;
         owner_q      <= owner_d;
`endif
      end
   end

   assign grantOut     = grant;
   assign xbarSelOut   = xbar_sel_q;
   assign flitValidOut = flit_valid_q;
   assign creditCntOut = credit_q;
   assign errOvfOut    = err_ovf_q;
`ifdef SA_OPORT_LOCK_EN
   assign lockedOut    = (state_q == LOCKED);
`else
   assign lockedOut    = 1'b0;
`endif

endmodule
